// File: rtl/sram_bus_sched.sv
// External SRAM cycle sequencer: CPU has absolute priority, ICD and DMA share
// the remaining slots round-robin. Every access is SETUP, STROBE_CYC strobe cycles, HOLD.
module sram_bus_sched #(
  parameter int ADDR_W     = 21,
  parameter int STROBE_CYC = 2
) (
  input  logic              clk6x,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_done,
  input  logic              aux_block,
  input  logic              icd_req,
  input  logic [ADDR_W-1:0] icd_addr,
  input  logic              icd_wr,
  input  logic [7:0]        icd_wdata,
  output logic              icd_ack,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_wr,
  input  logic [7:0]        dma_wdata,
  output logic              dma_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_wdata_oe,
  output logic              m1cs_n,
  output logic              mrd_n,
  output logic              mwr_n
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [7:0]        wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  typedef enum logic [1:0] {OWN_CPU, OWN_ICD, OWN_DMA} own_t;

  localparam logic [2:0] LAST = 3'(STROBE_CYC - 1);

  state_t     state_q, state_d;
  own_t       owner_q, grant_own;
  logic [2:0] cnt_q;
  logic       cur_wr_q;
  logic       cpu_pend_q;
  req_t       pend_q;
  logic       rr_q, rr_d;
  logic       grant;
  req_t       grant_req, cpu_in, icd_in, dma_in;
  logic       arb_ok, icd_v, dma_v, pick_icd, last_strobe, nxt_wr;

  assign cpu_in = '{addr: cpu_addr, wr: cpu_wr, wdata: cpu_wdata};
  assign icd_in = '{addr: icd_addr, wr: icd_wr, wdata: icd_wdata};
  assign dma_in = '{addr: dma_addr, wr: dma_wr, wdata: dma_wdata};

  assign arb_ok = (state_q == IDLE) || (state_q == HOLD);
  // The aux owner still holds its request during its own HOLD; mask it so the
  // same transfer is not granted twice.
  assign icd_v    = icd_req && !(state_q == HOLD && owner_q == OWN_ICD);
  assign dma_v    = dma_req && !(state_q == HOLD && owner_q == OWN_DMA);
  assign pick_icd = icd_v && (!dma_v || !rr_q);
  assign last_strobe = (state_q == STROBE) && (cnt_q == LAST);

  // rr_q: 0 = ICD preferred, 1 = DMA preferred; only moves when both contend.
  always_comb begin
    grant     = 1'b0;
    grant_own = OWN_CPU;
    grant_req = cpu_in;
    rr_d      = rr_q;
    if (arb_ok) begin
      if (cpu_req || cpu_pend_q) begin
        grant     = 1'b1;
        grant_req = cpu_req ? cpu_in : pend_q;
      end else if (!aux_block && (icd_v || dma_v)) begin
        grant     = 1'b1;
        grant_own = pick_icd ? OWN_ICD : OWN_DMA;
        grant_req = pick_icd ? icd_in : dma_in;
        if (icd_v && dma_v) rr_d = pick_icd;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  if (cnt_q == LAST) state_d = HOLD;
      HOLD:    state_d = grant ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign nxt_wr = grant ? grant_req.wr : cur_wr_q;

  always_ff @(posedge clk6x) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CPU;
      cnt_q        <= '0;
      cur_wr_q     <= 1'b0;
      cpu_pend_q   <= 1'b0;
      pend_q       <= '0;
      rr_q         <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wdata_oe <= 1'b0;
      m1cs_n       <= 1'b1;
      mrd_n        <= 1'b1;
      mwr_n        <= 1'b1;
      rdata        <= '0;
      cpu_done     <= 1'b0;
      icd_ack      <= 1'b0;
      dma_ack      <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= (state_q == STROBE) ? cnt_q + 3'd1 : 3'd0;
      if (grant) begin
        owner_q   <= grant_own;
        cur_wr_q  <= grant_req.wr;
        mem_addr  <= grant_req.addr;
        mem_wdata <= grant_req.wdata;
      end
      // A CPU strobe that is not granted this cycle waits in the pend slot.
      if (grant && grant_own == OWN_CPU) begin
        cpu_pend_q <= 1'b0;
      end else if (cpu_req) begin
        cpu_pend_q <= 1'b1;
        pend_q     <= cpu_in;
      end
      // Pin outputs are registered from the next state so they line up with it.
      m1cs_n       <= (state_d == IDLE);
      mem_wdata_oe <= (state_d != IDLE) && nxt_wr;
      mrd_n        <= !((state_d == STROBE) && !nxt_wr);
      mwr_n        <= !((state_d == STROBE) && nxt_wr);
      if (last_strobe && !cur_wr_q) rdata <= mem_rdata;
      cpu_done <= last_strobe && (owner_q == OWN_CPU);
      icd_ack  <= last_strobe && (owner_q == OWN_ICD);
      dma_ack  <= last_strobe && (owner_q == OWN_DMA);
    end
  end
endmodule

// File: tb/tb_sram_bus_sched.sv
// Directed and randomized bench for sram_bus_sched against a 256-byte SRAM pin
// model and a transaction-level reference memory updated at each done/ack.
module tb_sram_bus_sched;
  localparam int AW = 21;
  localparam int S  = 2;
  localparam int CPU = 0, ICD = 1, DMA = 2;

  logic clk6x = 1'b0;
  logic rst = 1'b1;
  logic cpu_req = 1'b0, cpu_wr = 1'b0, cpu_done;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic aux_block = 1'b0;
  logic icd_req = 1'b0, icd_wr = 1'b0, icd_ack;
  logic [AW-1:0] icd_addr = '0;
  logic [7:0] icd_wdata = '0;
  logic dma_req = 1'b0, dma_wr = 1'b0, dma_ack;
  logic [AW-1:0] dma_addr = '0;
  logic [7:0] dma_wdata = '0;
  logic [7:0] mem_rdata, rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic mem_wdata_oe, m1cs_n, mrd_n, mwr_n;

  always #5 clk6x = ~clk6x;

  sram_bus_sched #(.ADDR_W(AW), .STROBE_CYC(S)) dut (
    .clk6x(clk6x), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_done(cpu_done),
    .aux_block(aux_block),
    .icd_req(icd_req), .icd_addr(icd_addr), .icd_wr(icd_wr), .icd_wdata(icd_wdata), .icd_ack(icd_ack),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wr(dma_wr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
    .mem_rdata(mem_rdata), .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wdata_oe(mem_wdata_oe), .m1cs_n(m1cs_n), .mrd_n(mrd_n), .mwr_n(mwr_n)
  );

  function automatic logic [7:0] init_val(int i);
    return 8'(i * 37 + 11);
  endfunction

  // SRAM pin model: write lands on the clock edge while MWRn is low.
  logic [7:0] sram [256];
  always @(posedge clk6x) begin
    if (rst) for (int i = 0; i < 256; i++) sram[i] <= init_val(i);
    else if (!m1cs_n && !mwr_n) sram[mem_addr[7:0]] <= mem_wdata;
  end
  assign mem_rdata = (!m1cs_n && !mrd_n) ? sram[mem_addr[7:0]] : 8'hEE;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [7:0]    wdata;
  } txn_t;

  txn_t txn [3];
  bit   txn_v [3];
  logic [7:0] refm [256];
  int   checks = 0, errors = 0;
  int   run_wr = 0, run_rd = 0, cs_cnt = 0;
  bit [2:0] ack_now;
  bit   drop_icd = 0, drop_dma = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 256; i++) refm[i] = init_val(i);
    for (int k = 0; k < 3; k++) txn_v[k] = 0;
  endtask

  // Per-cycle protocol and data checks; completions retire the requester's txn.
  task automatic monitor(bit was_rst);
    ack_now = {dma_ack, icd_ack, cpu_done};
    if (was_rst) begin
      run_wr = 0; run_rd = 0; cs_cnt = 0;
      return;
    end
    if (!mwr_n) begin
      run_wr++;
      chk("oe_during_write", 32'(mem_wdata_oe), 1);
    end else if (run_wr != 0) begin
      chk("mwr_len", run_wr, S);
      run_wr = 0;
    end
    if (!mrd_n) begin
      run_rd++;
      chk("oe_during_read", 32'(mem_wdata_oe), 0);
    end else if (run_rd != 0) begin
      chk("mrd_len", run_rd, S);
      run_rd = 0;
    end
    if (!mrd_n || !mwr_n) chk("cs_with_strobe", 32'(m1cs_n), 0);
    if (!m1cs_n) cs_cnt++;
    if (ack_now != 3'b000) begin
      chk("ack_onehot", $countones(ack_now), 1);
      chk("cs_low_per_access", cs_cnt, S + 2);
      cs_cnt = 0;
      for (int k = 0; k < 3; k++) if (ack_now[k]) begin
        chk("ack_has_txn", 32'(txn_v[k]), 1);
        chk("hold_addr", 32'(mem_addr), 32'(txn[k].addr));
        if (txn[k].wr) refm[txn[k].addr[7:0]] = txn[k].wdata;
        else chk("rdata_vs_ref", 32'(rdata), 32'(refm[txn[k].addr[7:0]]));
        txn_v[k] = 0;
        if (k == ICD) drop_icd = 1;
        if (k == DMA) drop_dma = 1;
      end
    end
  endtask

  // One clock: CPU strobe is a single-cycle pulse, aux requests drop the cycle after ack.
  task automatic tick();
    bit r;
    r = rst;
    @(posedge clk6x);
    #1;
    cpu_req   = 1'b0;
    cpu_addr  = AW'($urandom);
    cpu_wr    = 1'($urandom);
    cpu_wdata = 8'($urandom);
    if (drop_icd) begin icd_req = 1'b0; drop_icd = 0; end
    if (drop_dma) begin dma_req = 1'b0; drop_dma = 0; end
    monitor(r);
  endtask

  task automatic cpu_issue(logic [AW-1:0] a, logic w, logic [7:0] d);
    cpu_req = 1'b1; cpu_addr = a; cpu_wr = w; cpu_wdata = d;
    txn[CPU] = '{a, w, d};
    txn_v[CPU] = 1;
  endtask

  task automatic aux_issue(int k, logic [AW-1:0] a, logic w, logic [7:0] d);
    if (k == ICD) begin icd_req = 1'b1; icd_addr = a; icd_wr = w; icd_wdata = d; end
    else begin dma_req = 1'b1; dma_addr = a; dma_wr = w; dma_wdata = d; end
    txn[k] = '{a, w, d};
    txn_v[k] = 1;
  endtask

  task automatic wait_ack(int k, int exp, string tag);
    int lat = 0;
    do begin
      tick();
      lat++;
    end while (!ack_now[k] && lat < 40);
    chk(tag, lat, exp);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return {13'($urandom), 4'h0, 4'($urandom)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int act, b;
    // Reset state
    ref_reset();
    rst = 1'b1;
    tick(); tick();
    chk("rst_cs", 32'(m1cs_n), 1);
    chk("rst_rd", 32'(mrd_n), 1);
    chk("rst_wr", 32'(mwr_n), 1);
    chk("rst_oe", 32'(mem_wdata_oe), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_acks", 32'({cpu_done, icd_ack, dma_ack}), 0);
    rst = 1'b0;
    tick();

    // CPU write then read-back, cycle by cycle
    cpu_issue(21'h10, 1'b1, 8'h12);
    tick();
    chk("t1_setup_cs", 32'(m1cs_n), 0);
    chk("t1_setup_wr", 32'(mwr_n), 1);
    chk("t1_setup_oe", 32'(mem_wdata_oe), 1);
    chk("t1_setup_addr", 32'(mem_addr), 32'h10);
    chk("t1_setup_wdata", 32'(mem_wdata), 32'h12);
    tick(); chk("t1_strobe1", 32'(mwr_n), 0);
    tick(); chk("t1_strobe2", 32'(mwr_n), 0);
    tick();
    chk("t1_hold_done", 32'(cpu_done), 1);
    chk("t1_hold_wr", 32'(mwr_n), 1);
    chk("t1_hold_cs", 32'(m1cs_n), 0);
    tick();
    chk("t1_idle_done", 32'(cpu_done), 0);
    chk("t1_idle_cs", 32'(m1cs_n), 1);
    chk("t1_idle_oe", 32'(mem_wdata_oe), 0);
    cpu_issue(21'h10, 1'b0, 8'h00);
    wait_ack(CPU, S + 2, "t1_read_latency");
    chk("t1_read_data", 32'(rdata), 32'h12);
    tick();

    // ICD and DMA together: ICD first, DMA back-to-back, then DMA first
    aux_issue(ICD, 21'h20, 1'b1, 8'h34);
    aux_issue(DMA, 21'h10, 1'b0, 8'h00);
    wait_ack(ICD, S + 2, "t2_icd_latency");
    tick();
    chk("t2_b2b_setup_cs", 32'(m1cs_n), 0);
    chk("t2_b2b_setup_addr", 32'(mem_addr), 32'h10);
    wait_ack(DMA, S + 1, "t2_dma_latency");
    chk("t2_dma_rdata", 32'(rdata), 32'h12);
    tick(); tick();
    aux_issue(ICD, 21'h21, 1'b0, 8'h00);
    aux_issue(DMA, 21'h20, 1'b0, 8'h00);
    wait_ack(DMA, S + 2, "t2_rr_dma_first");
    chk("t2_rr_dma_rdata", 32'(rdata), 32'h34);
    wait_ack(ICD, S + 2, "t2_rr_icd_second");
    chk("t2_rr_icd_rdata", 32'(rdata), 32'(init_val(8'h21)));
    tick(); tick();

    // CPU request arriving during a DMA strobe is served right after it
    aux_issue(DMA, 21'h20, 1'b0, 8'h00);
    tick(); tick();
    chk("t3_in_strobe", 32'(mrd_n), 0);
    cpu_issue(21'h0000AB, 1'b1, 8'hAB);
    wait_ack(DMA, 2, "t3_dma_ack");
    chk("t3_dma_rdata", 32'(rdata), 32'h34);
    tick();
    chk("t3_cpu_setup_cs", 32'(m1cs_n), 0);
    chk("t3_cpu_setup_wr", 32'(mwr_n), 1);
    chk("t3_cpu_setup_oe", 32'(mem_wdata_oe), 1);
    chk("t3_cpu_setup_addr", 32'(mem_addr), 32'hAB);
    wait_ack(CPU, S + 1, "t3_cpu_done");
    tick();
    chk("t3_sram_ab", 32'(sram[8'hAB]), 32'hAB);

    // aux_block holds off ICD until released
    aux_block = 1'b1;
    aux_issue(ICD, 21'h100AB, 1'b0, 8'h00);
    act = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!m1cs_n) act++;
    end
    chk("t4_blocked_cs", act, 0);
    aux_block = 1'b0;
    wait_ack(ICD, S + 2, "t4_icd_latency");
    chk("t4_icd_rdata", 32'(rdata), 32'hAB);
    tick();

    // Random mix of all three requesters
    for (int c = 0; c < 3000; c++) begin
      aux_block = ($urandom % 4 == 0);
      if (!txn_v[CPU] && $urandom % 6 == 0) cpu_issue(rand_addr(), 1'($urandom), 8'($urandom));
      if (!icd_req && !txn_v[ICD] && $urandom % 5 == 0) aux_issue(ICD, rand_addr(), 1'($urandom), 8'($urandom));
      if (!dma_req && !txn_v[DMA] && $urandom % 5 == 0) aux_issue(DMA, rand_addr(), 1'($urandom), 8'($urandom));
      tick();
    end
    aux_block = 1'b0;
    b = 0;
    while ((txn_v[CPU] || txn_v[ICD] || txn_v[DMA]) && b < 200) begin
      tick();
      b++;
    end
    chk("rand_drain", 32'({txn_v[CPU], txn_v[ICD], txn_v[DMA]}), 0);
    tick(); tick();

    // Reset during the strobe of a write, with a second CPU request pending
    cpu_issue(21'h30, 1'b1, 8'h77);
    tick();
    chk("t5_setup_cs", 32'(m1cs_n), 0);
    cpu_issue(21'h31, 1'b1, 8'h99);
    tick();
    chk("t5_strobe_wr", 32'(mwr_n), 0);
    rst = 1'b1;
    ref_reset();
    tick();
    chk("t5_rst_cs", 32'(m1cs_n), 1);
    chk("t5_rst_wr", 32'(mwr_n), 1);
    chk("t5_rst_oe", 32'(mem_wdata_oe), 0);
    chk("t5_rst_done", 32'(cpu_done), 0);
    rst = 1'b0;
    act = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!m1cs_n || ack_now != 3'b000) act++;
    end
    chk("t5_pend_discarded", act, 0);
    cpu_issue(21'h31, 1'b0, 8'h00);
    wait_ack(CPU, S + 2, "t5_read_latency");
    chk("t5_read_data", 32'(rdata), 32'(init_val(8'h31)));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
